// File: rtl/peng_timer_ctrl.sv
// Countdown-timer controller: turns the divider's tick square wave into a
// minutes:seconds countdown with set / run / pause / alarm phases.
module peng_timer_ctrl #(
  parameter int unsigned TICK_HZ   = 64,
  parameter int unsigned MAX_MIN   = 99,
  parameter int unsigned ALARM_SEC = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       btn_start,
  input  logic       btn_clr,
  input  logic       btn_min,
  input  logic       btn_sec,
  output logic [6:0] min_out,
  output logic [5:0] sec_out,
  output logic       running,
  output logic       paused,
  output logic       alarm,
  output logic       blink
);

  localparam int unsigned FW        = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;
  localparam int unsigned ALM_TICKS = ALARM_SEC * TICK_HZ;
  localparam int unsigned AW        = (ALM_TICKS > 1) ? $clog2(ALM_TICKS) : 1;
  localparam logic [FW-1:0] FRAC_TOP = FW'(TICK_HZ - 1);
  localparam logic [AW-1:0] ALM_TOP  = AW'(ALM_TICKS - 1);
  localparam logic [6:0]    MIN_TOP  = 7'(MAX_MIN);
  localparam logic [5:0]    SEC_TOP  = 6'd59;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [6:0]    pre_min, pre_min_n, cnt_min, cnt_min_n;
  logic [5:0]    pre_sec, pre_sec_n, cnt_sec, cnt_sec_n;
  logic [FW-1:0] frac, frac_n, frac_sav, frac_sav_n;
  logic [AW-1:0] alm_cnt, alm_cnt_n;
  logic          tick_q;
  logic          tick;
  logic          preset_zero;

  // One-cycle strobe on each rising edge of the same-domain tick wave
  assign tick        = tick_in & ~tick_q;
  assign preset_zero = (pre_min == 7'd0) && (pre_sec == 6'd0);

  always_comb begin
    state_n    = state;
    pre_min_n  = pre_min;
    pre_sec_n  = pre_sec;
    cnt_min_n  = cnt_min;
    cnt_sec_n  = cnt_sec;
    frac_n     = frac;
    frac_sav_n = frac_sav;
    alm_cnt_n  = alm_cnt;

    if (btn_clr) begin
      state_n   = S_IDLE;
      frac_n    = '0;
      alm_cnt_n = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (btn_start && !preset_zero) begin
            cnt_min_n = pre_min;
            cnt_sec_n = pre_sec;
            frac_n    = FRAC_TOP;
            state_n   = S_RUN;
          end else if (!btn_start) begin
            if (btn_min) pre_min_n = (pre_min >= MIN_TOP) ? 7'd0 : pre_min + 7'd1;
            if (btn_sec) pre_sec_n = (pre_sec >= SEC_TOP) ? 6'd0 : pre_sec + 6'd1;
          end
        end

        S_RUN: begin
          if (btn_start) begin
            frac_sav_n = frac;
            state_n    = S_PAUSE;
          end else if (tick) begin
            if (frac != '0) begin
              frac_n = frac - FW'(1);
            end else begin
              frac_n = FRAC_TOP;
              if (cnt_sec != 6'd0) begin
                cnt_sec_n = cnt_sec - 6'd1;
              end else begin
                cnt_sec_n = SEC_TOP;
                cnt_min_n = cnt_min - 7'd1;
              end
              if (cnt_min == 7'd0 && cnt_sec == 6'd1) begin
                alm_cnt_n = '0;
                state_n   = S_ALARM;
              end
            end
          end
        end

        // frac free-runs as the blink phase; the countdown phase lives in frac_sav
        S_PAUSE: begin
          if (btn_start) begin
            frac_n  = frac_sav;
            state_n = S_RUN;
          end else if (tick) begin
            frac_n = (frac == '0) ? FRAC_TOP : frac - FW'(1);
          end
        end

        S_ALARM: begin
          if (btn_start || btn_min || btn_sec || (tick && alm_cnt == ALM_TOP)) begin
            alm_cnt_n = '0;
            state_n   = S_IDLE;
          end else if (tick) begin
            alm_cnt_n = alm_cnt + AW'(1);
          end
        end

        default: state_n = S_IDLE;
      endcase
    end
  end

  // State, counters and outputs all registered from the next-state values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pre_min  <= '0;
      pre_sec  <= '0;
      cnt_min  <= '0;
      cnt_sec  <= '0;
      frac     <= '0;
      frac_sav <= '0;
      alm_cnt  <= '0;
      tick_q   <= 1'b0;
      min_out  <= '0;
      sec_out  <= '0;
      running  <= 1'b0;
      paused   <= 1'b0;
      alarm    <= 1'b0;
      blink    <= 1'b0;
    end else begin
      state    <= state_n;
      pre_min  <= pre_min_n;
      pre_sec  <= pre_sec_n;
      cnt_min  <= cnt_min_n;
      cnt_sec  <= cnt_sec_n;
      frac     <= frac_n;
      frac_sav <= frac_sav_n;
      alm_cnt  <= alm_cnt_n;
      tick_q   <= tick_in;
      min_out  <= (state_n == S_IDLE) ? pre_min_n : cnt_min_n;
      sec_out  <= (state_n == S_IDLE) ? pre_sec_n : cnt_sec_n;
      running  <= (state_n == S_RUN);
      paused   <= (state_n == S_PAUSE);
      alarm    <= (state_n == S_ALARM);
      blink    <= (state_n == S_PAUSE) ? frac_n[FW-1] : 1'b0;
    end
  end

endmodule

// File: tb/tb_peng_timer_ctrl.sv
// Scoreboard bench for peng_timer_ctrl with TICK_HZ=4, ALARM_SEC=2.
module tb_peng_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_clr = 1'b0;
  logic       btn_min = 1'b0;
  logic       btn_sec = 1'b0;
  logic [6:0] min_out;
  logic [5:0] sec_out;
  logic       running, paused, alarm, blink;

  typedef struct {
    string       name;
    logic [16:0] v;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  peng_timer_ctrl #(.TICK_HZ(4), .MAX_MIN(99), .ALARM_SEC(2)) dut (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in),
    .btn_start(btn_start), .btn_clr(btn_clr), .btn_min(btn_min), .btn_sec(btn_sec),
    .min_out(min_out), .sec_out(sec_out),
    .running(running), .paused(paused), .alarm(alarm), .blink(blink)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] ev(int m, int s, logic r, logic p, logic a, logic b);
    return {7'(m), 6'(s), r, p, a, b};
  endfunction

  function automatic logic [16:0] obs();
    return {min_out, sec_out, running, paused, alarm, blink};
  endfunction

  task automatic push(string n, logic [16:0] v);
    exp_t e;
    e.name = n;
    e.v    = v;
    sb.push_back(e);
  endtask

  task automatic press(logic s, logic c, logic m, logic x);
    btn_start = s; btn_clr = c; btn_min = m; btn_sec = x;
    @(negedge clk);
    btn_start = 1'b0; btn_clr = 1'b0; btn_min = 1'b0; btn_sec = 1'b0;
  endtask

  task automatic ticks(int n);
    repeat (n) begin
      tick_in = 1'b1;
      repeat (4) @(negedge clk);
      tick_in = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick_in = 1'b0;
    btn_start = 1'b0; btn_clr = 1'b0; btn_min = 1'b0; btn_sec = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    push("reset_hold", ev(0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    rst_n = 1'b1;
    push("reset_release", ev(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
  endtask

  task automatic test_preset();
    exp_t e;
    do_reset();
    repeat (3) press(0, 0, 0, 1);
    push("preset_1_03", ev(1, 3, 0, 0, 0, 0));
    press(0, 0, 1, 0);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    push("preset_sec_wrap", ev(1, 0, 0, 0, 0, 0));
    repeat (57) press(0, 0, 0, 1);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    push("preset_min_99", ev(99, 0, 0, 0, 0, 0));
    repeat (98) press(0, 0, 1, 0);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    push("preset_min_wrap", ev(0, 0, 0, 0, 0, 0));
    press(0, 0, 1, 0);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
  endtask

  task automatic test_countdown();
    exp_t e;
    do_reset();
    repeat (2) press(0, 0, 0, 1);
    push("cd_start", ev(0, 2, 1, 0, 0, 0));
    press(1, 0, 0, 0);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    push("cd_4_ticks", ev(0, 1, 1, 0, 0, 0));
    ticks(4);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    push("cd_7_ticks", ev(0, 1, 1, 0, 0, 0));
    ticks(3);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    push("cd_alarm", ev(0, 0, 0, 0, 1, 0));
    ticks(1);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    push("cd_alarm_held", ev(0, 0, 0, 0, 1, 0));
    ticks(7);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    push("cd_alarm_end", ev(0, 2, 0, 0, 0, 0));
    ticks(1);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
  endtask

  task automatic test_pause();
    exp_t e;
    logic [1:0] pf;
    do_reset();
    repeat (5) press(0, 0, 0, 1);
    press(1, 0, 0, 0);
    ticks(6);
    pf = 2'd1;
    push("pause_enter", ev(0, 4, 0, 1, 0, pf[1]));
    press(1, 0, 0, 0);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    for (int i = 0; i < 10; i++) begin
      pf = (pf == 2'd0) ? 2'd3 : pf - 2'd1;
      push($sformatf("pause_tick%0d", i), ev(0, 4, 0, 1, 0, pf[1]));
      ticks(1);
      e = sb.pop_front(); total++;
      if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    end
    push("pause_resume", ev(0, 4, 1, 0, 0, 0));
    press(1, 0, 0, 0);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    push("resume_1_tick", ev(0, 4, 1, 0, 0, 0));
    ticks(1);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    push("resume_2_ticks", ev(0, 3, 1, 0, 0, 0));
    ticks(1);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    push("pause_clr", ev(0, 5, 0, 0, 0, 0));
    press(0, 1, 0, 0);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
  endtask

  task automatic test_collisions();
    exp_t e;
    do_reset();
    press(0, 0, 0, 1);
    press(1, 0, 0, 0);
    ticks(1);
    // start on the same cycle as a tick: tick dropped, frac stays 2 (blink=1)
    push("start_with_tick", ev(0, 1, 0, 1, 0, 1));
    tick_in = 1'b1;
    press(1, 0, 0, 0);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    repeat (3) @(negedge clk);
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
    press(1, 0, 0, 0);
    push("collide_2_more", ev(0, 1, 1, 0, 0, 0));
    ticks(2);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    push("collide_3rd_alarm", ev(0, 0, 0, 0, 1, 0));
    ticks(1);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    push("clr_with_start", ev(0, 1, 0, 0, 0, 0));
    press(1, 1, 0, 0);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    push("start_with_min", ev(0, 1, 1, 0, 0, 0));
    press(1, 0, 1, 0);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    push("min_discarded", ev(0, 1, 0, 0, 0, 0));
    press(0, 1, 0, 0);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    do_reset();
    push("start_zero_preset", ev(0, 0, 0, 0, 0, 0));
    press(1, 0, 0, 0);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
  endtask

  task automatic test_alarm_abort();
    exp_t e;
    do_reset();
    repeat (2) press(0, 0, 0, 1);
    press(1, 0, 0, 0);
    push("abort_in_alarm", ev(0, 0, 0, 0, 1, 0));
    ticks(8);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    push("abort_btn_min", ev(0, 2, 0, 0, 0, 0));
    press(0, 0, 1, 0);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
  endtask

  task automatic test_async_reset();
    exp_t e;
    do_reset();
    repeat (3) press(0, 0, 0, 1);
    press(1, 0, 0, 0);
    push("pre_reset_run", ev(0, 3, 1, 0, 0, 0));
    ticks(2);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    push("async_reset", ev(0, 0, 0, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    push("after_release", ev(0, 0, 0, 0, 0, 0));
    ticks(1);
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.name, obs(), e.v); else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_preset();
    test_countdown();
    test_pause();
    test_collisions();
    test_alarm_abort();
    test_async_reset();
    if (sb.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
